// File: rtl/rx_byte_assembler_pkg.sv
// Shared rx definitions: assembler state encoding and byte/parity geometry.
package rx_byte_assembler_pkg;

  localparam int unsigned BYTE_BITS                 = 8;
  localparam int unsigned BITS_PER_BYTE_WITH_PARITY = 9;
  localparam int unsigned CNT_W                     = 4;  // holds 0..8

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    ERR  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/rx_byte_assembler.sv
// Assembles LSB-first received bits (each byte followed by an odd parity bit)
// into byte-level events. All outputs are registered, one clk after the
// input pulse that completes the event.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_soc, in_eoc        start/end of frame pulses
//   in_error              framing/line error pulse
//   in_data_valid, in_data  one received bit per valid pulse
//   out_soc, out_eoc, out_error, out_data_valid  byte-level event flags
//   out_data              assembled byte
//   out_data_bits         0 = full byte, 1..7 = bits in a partial final byte
module rx_byte_assembler
  import rx_byte_assembler_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_soc,
  input  logic       in_eoc,
  input  logic       in_error,
  input  logic       in_data_valid,
  input  logic       in_data,
  output logic       out_soc,
  output logic       out_eoc,
  output logic       out_error,
  output logic       out_data_valid,
  output logic [7:0] out_data,
  output logic [2:0] out_data_bits
);

  rx_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   par_q, par_d;
  logic                   seen_q, seen_d;
  logic [BYTE_BITS-1:0]   data_q, data_d;

  logic                   soc_d, eoc_d, err_d, dv_d;
  logic [BYTE_BITS-1:0]   odata_d;
  logic [2:0]             obits_d;

  // State, frame accumulators and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      par_q          <= 1'b0;
      seen_q         <= 1'b0;
      data_q         <= '0;
      out_soc        <= 1'b0;
      out_eoc        <= 1'b0;
      out_error      <= 1'b0;
      out_data_valid <= 1'b0;
      out_data       <= 8'h00;
      out_data_bits  <= 3'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      par_q          <= par_d;
      seen_q         <= seen_d;
      data_q         <= data_d;
      out_soc        <= soc_d;
      out_eoc        <= eoc_d;
      out_error      <= err_d;
      out_data_valid <= dv_d;
      out_data       <= odata_d;
      out_data_bits  <= obits_d;
    end
  end

  // Next-state and event decode; in_soc restarts, then in_eoc beats bits
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    seen_d  = seen_q;
    data_d  = data_q;
    soc_d   = 1'b0;
    eoc_d   = 1'b0;
    err_d   = 1'b0;
    dv_d    = 1'b0;
    odata_d = '0;
    obits_d = 3'd0;

    if (in_soc) begin
      state_d = RX;
      cnt_d   = '0;
      par_d   = 1'b0;
      seen_d  = 1'b0;
      data_d  = '0;
      soc_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: ;
        ERR: begin
          if (in_eoc) begin
            eoc_d   = 1'b1;
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        RX: begin
          if (in_eoc) begin
            eoc_d   = 1'b1;
            state_d = IDLE;
            if (in_error) begin
              err_d = 1'b1;
            end else if (cnt_q == '0) begin
              err_d = !seen_q;  // empty frame
            end else if (cnt_q == CNT_W'(BYTE_BITS)) begin
              err_d = 1'b1;     // parity bit never arrived
            end else begin
              // Bits above cnt are zero since data is cleared per byte
              dv_d    = 1'b1;
              odata_d = data_q;
              obits_d = cnt_q[2:0];
            end
          end else if (in_error) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else if (in_data_valid) begin
            if (cnt_q == CNT_W'(BYTE_BITS)) begin
              if (par_q ^ in_data) begin
                dv_d    = 1'b1;
                odata_d = data_q;
                seen_d  = 1'b1;
              end else begin
                err_d   = 1'b1;
                state_d = ERR;
              end
              cnt_d  = '0;
              par_d  = 1'b0;
              data_d = '0;
            end else begin
              data_d[cnt_q[2:0]] = in_data;
              par_d              = par_q ^ in_data;
              cnt_d              = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_byte_assembler.sv
// Randomized and directed bench for rx_byte_assembler against a frame-level
// reference model built from a queue of the bits received in the frame.
module tb_rx_byte_assembler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_soc, in_eoc, in_error, in_data_valid, in_data;
  logic       out_soc, out_eoc, out_error, out_data_valid;
  logic [7:0] out_data;
  logic [2:0] out_data_bits;

  rx_byte_assembler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_soc        (in_soc),
    .in_eoc        (in_eoc),
    .in_error      (in_error),
    .in_data_valid (in_data_valid),
    .in_data       (in_data),
    .out_soc       (out_soc),
    .out_eoc       (out_eoc),
    .out_error     (out_error),
    .out_data_valid(out_data_valid),
    .out_data      (out_data),
    .out_data_bits (out_data_bits)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: 0 = waiting for soc, 1 = in frame, 2 = frame broken
  int   m_mode = 0;
  bit   m_bits[$];
  bit   m_seen = 0;
  bit   e_soc, e_eoc, e_err, e_dv;
  logic [7:0] e_data;
  int   e_nbits;
  int   dv_count = 0;

  function automatic logic [7:0] pack_bits(input int n);
    logic [7:0] v = 8'h00;
    for (int i = 0; i < n; i++) v[i] = m_bits[i];
    return v;
  endfunction

  task automatic model(input bit soc, eoc, err, dv, d);
    int ones;
    e_soc = 0; e_eoc = 0; e_err = 0; e_dv = 0; e_data = 8'h00; e_nbits = 0;
    if (soc) begin
      m_mode = 1; m_bits.delete(); m_seen = 0; e_soc = 1;
    end else if (m_mode == 2) begin
      if (eoc) begin e_eoc = 1; e_err = 1; m_mode = 0; end
    end else if (m_mode == 1) begin
      if (eoc) begin
        e_eoc = 1; m_mode = 0;
        if (err) e_err = 1;
        else if (m_bits.size() == 0) e_err = !m_seen;
        else if (m_bits.size() == 8) e_err = 1;
        else begin
          e_dv = 1; e_nbits = m_bits.size(); e_data = pack_bits(m_bits.size());
        end
      end else if (err) begin
        e_err = 1; m_mode = 2;
      end else if (dv) begin
        m_bits.push_back(d);
        if (m_bits.size() == 9) begin
          ones = 0;
          foreach (m_bits[i]) ones += int'(m_bits[i]);
          if (ones % 2 == 1) begin
            e_dv = 1; e_data = pack_bits(8); e_nbits = 0; m_seen = 1;
          end else begin
            e_err = 1; m_mode = 2;
          end
          m_bits.delete();
        end
      end
    end
  endtask

  // One clock of stimulus; outputs compared 1 ns after the edge
  task automatic step(input bit soc, eoc, err, dv, d);
    in_soc = soc; in_eoc = eoc; in_error = err; in_data_valid = dv; in_data = d;
    model(soc, eoc, err, dv, d);
    @(posedge clk); #1;
    check("soc", 32'(out_soc), 32'(e_soc));
    check("eoc", 32'(out_eoc), 32'(e_eoc));
    check("err", 32'(out_error), 32'(e_err));
    check("dv", 32'(out_data_valid), 32'(e_dv));
    if (e_dv) begin
      dv_count++;
      check("data", 32'(out_data), 32'(e_data));
      check("data_bits", 32'(out_data_bits), 32'(e_nbits));
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, v[i]);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit p);
    send_bits(v, 8);
    step(0, 0, 0, 1, p);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_flags"}, 32'({out_soc, out_eoc, out_error, out_data_valid}), 32'd0);
    check({tag, "_data"}, 32'(out_data), 32'd0);
    check({tag, "_bits"}, 32'(out_data_bits), 32'd0);
  endtask

  // Assert reset between edges; outputs must clear without a clock edge
  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero(tag);
    m_mode = 0; m_bits.delete(); m_seen = 0;
    in_soc = 0; in_eoc = 0; in_error = 0; in_data_valid = 0; in_data = 0;
    @(posedge clk); #1;
    check_outputs_zero({tag, "_held"});
    rst_n = 1'b1;
  endtask

  initial begin
    int dv_before;
    rst_n = 1'b0;
    in_soc = 0; in_eoc = 0; in_error = 0; in_data_valid = 0; in_data = 0;
    #3 check_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();

    // Two good bytes then eoc
    step(1, 0, 0, 0, 0);
    send_byte(8'h93, 1); send_byte(8'h20, 0);
    step(0, 1, 0, 0, 0);
    idle();

    // REQA short frame, 7 bits
    step(1, 0, 0, 0, 0);
    send_bits(8'h26, 7);
    step(0, 1, 0, 0, 0);

    // Parity error, trailing bits discarded
    dv_before = dv_count;
    step(1, 0, 0, 0, 0);
    send_byte(8'h93, 0);
    send_bits(8'h1f, 5);
    step(0, 1, 0, 0, 0);
    check("no_dv_after_parity_err", 32'(dv_count), 32'(dv_before));

    // Two bytes plus a 3-bit tail
    step(1, 0, 0, 0, 0);
    send_byte(8'h93, 1); send_byte(8'h20, 0);
    send_bits(8'h05, 3);
    step(0, 1, 0, 0, 0);

    // Missing parity bit
    step(1, 0, 0, 0, 0);
    send_bits(8'h55, 8);
    step(0, 1, 0, 0, 0);

    // Empty frame, error with eoc, eoc with coincident bit
    step(1, 0, 0, 0, 0); step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0); send_bits(8'h03, 2); step(0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0); send_bits(8'h03, 2); step(0, 1, 0, 1, 1);

    // Reset mid-frame after 4 bits: no eoc, then a clean frame
    step(1, 0, 0, 0, 0);
    send_bits(8'h0a, 4);
    pulse_reset("rst_mid");
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0); send_byte(8'h93, 1); step(0, 1, 0, 0, 0);

    // Reset right after a data event, output must drop asynchronously
    step(1, 0, 0, 0, 0); send_byte(8'h41, 1);
    pulse_reset("rst_after_dv");

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      bit soc, eoc, err, dv;
      r   = int'($urandom_range(0, 999));
      soc = (r < 15);
      eoc = (r >= 15 && r < 40) || ($urandom_range(0, 99) == 0);
      err = ($urandom_range(0, 199) == 0);
      dv  = ($urandom_range(0, 9) < 7);
      step(soc, eoc, err, dv, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_byte_assembler.md
RX_BYTE_ASSEMBLER -- requirements
Module: rx_byte_assembler

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; clk and rst_n are the only clock and reset.
REQ-002 clk  input  1  system clock; all state updates on posedge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_soc  input  1  start-of-frame pulse from bit-level frame decode.
REQ-005 in_eoc  input  1  end-of-frame pulse.
REQ-006 in_error  input  1  framing or line error pulse from frame decode.
REQ-007 in_data_valid  input  1  qualifies in_data; one pulse per received bit.
REQ-008 in_data  input  1  received bit, LSB-first order, each byte followed by one odd parity bit.
REQ-009 out_soc, out_eoc, out_error, out_data_valid  output  1 each  byte-level event flags.
REQ-010 out_data  output  8  assembled byte.
REQ-011 out_data_bits  output  3  0 = full byte, 1..7 = valid bits in a partial final byte.

Function
REQ-012 SHALL register all outputs, so an event appears exactly 1 clk after the input pulse that completes it.
REQ-013 States SHALL be IDLE, RX and ERR.
REQ-014 IDLE: in_soc -> RX, emit out_soc alone, clear bit counter (0..8), parity accumulator and byte_seen; all other inputs ignored.
REQ-015 RX, in_data_valid, count 0..7: store in_data at data bit [count], XOR it into the parity accumulator, increment count.
REQ-016 RX, in_data_valid, count 8: parity bit. If accumulator XOR bit = 1 (odd parity OK), emit out_data_valid with out_data_bits 0, set byte_seen and set count 0; otherwise emit out_error alone and go to ERR.
REQ-017 RX, in_eoc, count 0, byte_seen=1: emit out_eoc with out_error 0 and out_data_valid 0, then go to IDLE.
REQ-018 RX, in_eoc, count 0, byte_seen=0 (empty frame): emit out_eoc with out_error 1, then go to IDLE.
REQ-019 RX, in_eoc, count 1..7: emit out_eoc with out_data_valid 1, out_data_bits = count and out_data[count-1:0] valid, then go to IDLE.
REQ-020 RX, in_eoc, count 8 (missing parity bit): emit out_eoc with out_error 1 and out_data_valid 0, then go to IDLE.
REQ-021 RX, in_error without in_eoc: emit out_error alone and go to ERR; in_error together with in_eoc: emit out_eoc plus out_error, then go to IDLE.
REQ-022 ERR SHALL discard all bits; in_eoc emits out_eoc with out_error 1, then goes to IDLE.
REQ-023 in_soc in RX or ERR SHALL discard the partial byte, emit out_soc and restart the frame (RX, counters cleared).
REQ-024 in_data_valid coincident with in_eoc SHALL have its bit ignored; in_eoc takes priority.
REQ-025 Outputs with no event SHALL drive all flags 0; out_data and out_data_bits are don't-care when out_data_valid is 0.

Reset
REQ-026 rst_n low SHALL force state IDLE, all counters and flags 0, out_data 8'h00 and out_data_bits 3'd0, immediately and independent of clk.
REQ-027 Reset asserted mid-frame SHALL produce no out_eoc; the next activity requires in_soc.

Structure
REQ-028 The state enum, BYTE_BITS=8 and BITS_PER_BYTE_WITH_PARITY=9 SHALL live in a shared rx package.
REQ-029 No sub-module; parity is accumulated inline.

Verification
REQ-030 soc; bits of 0x93 (parity 1) and 0x20 (parity 0); eoc -> soc, dv 0x93 bits 0, dv 0x20 bits 0, eoc err 0.
REQ-031 soc; 7 bits of 0x26 (REQA short frame, no parity); eoc -> soc, then eoc plus dv with data_bits 7, data[6:0]=7'h26.
REQ-032 soc; 0x93 with parity 0; 5 more bits; eoc -> soc, error alone, then eoc err 1; no dv event.
REQ-033 soc; 0x93/1, 0x20/0, bits 1,0,1; eoc -> two full-byte dv events, then eoc plus dv with data_bits 3, data[2:0]=3'b101.
REQ-034 soc; 8 bits of 0x55 with no parity; eoc -> soc, eoc err 1; separately, rst_n low after 4 bits -> outputs 0, no eoc, next soc frame is clean.
